sum_display: RTL

Downstream consumer of the 4-bit adder's 5-bit `result`. The block captures a sum on a load strobe and converts it to two BCD digits with a sequential 5-step double-dabble. It drives a time-multiplexed two-digit active-low seven-segment display. It sits between the adder datapath and the board's display pins.

---
 rtl/sum_display.sv | 130 +++++++++++++
 1 files changed

// File: rtl/sum_display.sv
// Captures a 5-bit adder sum, converts it to two BCD digits with a sequential
// double-dabble, and drives a multiplexed two-digit active-low 7-segment display.
// Optional leading-zero blanking of the tens digit: define SUM_DISP_BLANK_EN.
module sum_display #(
  parameter int REFRESH_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] result,
  input  logic       load,
  output logic       busy,
  output logic       done,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic [6:0] seg,
  output logic [1:0] an
);

  localparam int             CW   = (REFRESH_CYCLES > 2) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [CW-1:0]  LAST = CW'(REFRESH_CYCLES - 1);
  localparam logic [2:0]     LAST_STEP = 3'd4;

  typedef enum logic {IDLE, CONVERT} state_t;

  state_t     state;
  logic [2:0] step;
  logic [4:0] shift_reg;
  logic [7:0] scratch;
  logic [7:0] adj;
  logic [7:0] next_scratch;
  logic [4:0] next_shift;

  // One double-dabble iteration: correct nibbles >= 5, then shift the whole
  // {scratch, shift_reg} word left by one.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    adj = scratch;
    if (scratch[7:4] >= 4'd5) adj[7:4] = scratch[7:4] + 4'd3;
    if (scratch[3:0] >= 4'd5) adj[3:0] = scratch[3:0] + 4'd3;
    next_scratch = {adj[6:0], shift_reg[4]};
    next_shift   = {shift_reg[3:0], 1'b0};
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      step      <= '0;
      shift_reg <= '0;
      scratch   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      tens      <= '0;
      ones      <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (load) begin
            shift_reg <= result;
            scratch   <= '0;
            step      <= '0;
            busy      <= 1'b1;
            state     <= CONVERT;
          end
        end
        CONVERT: begin
          scratch   <= next_scratch;
          shift_reg <= next_shift;
          step      <= step + 3'd1;
          if (step == LAST_STEP) begin
            // Digits are published only once complete, so the display never
            // shows a half-converted value.
            tens  <= next_scratch[7:4];
            ones  <= next_scratch[3:0];
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Digit multiplexing runs free of the converter.
  logic [CW-1:0] refresh_cnt;
  logic          sel_tens;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refresh_cnt <= '0;
      sel_tens    <= 1'b0;
    end else if (refresh_cnt == LAST) begin
      refresh_cnt <= '0;
      sel_tens    <= ~sel_tens;
    end else begin
      refresh_cnt <= refresh_cnt + 1'b1;
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  always_comb begin
    an  = sel_tens ? 2'b01 : 2'b10;
    seg = seg7(sel_tens ? tens : ones);
`ifdef SUM_DISP_BLANK_EN
    if (sel_tens && tens == 4'd0) begin
      an  = 2'b11;
      seg = 7'h7F;
    end
`endif
  end

endmodule
